lfsr_stim_gen: RTL and testbench
================================

# lfsr_stim_gen

Synthesizable pseudo-random stimulus source for the circuit-equivalence benches. It drives operand vectors into both the reference circuit and the autogenerated circuit. It also emits a check-valid strobe, delayed by the circuit latency, that qualifies the downstream error monitor. It is the transmit end of the stimulus/check path that the monitor receives.

## Interface
Parameters:
- DATAWIDTH, 32, width of Data; legal 1..32 (Data = low DATAWIDTH bits of LFSR state)
- SEED, 32'hACE12B37, LFSR load value on Start; SEED==0 is replaced by 32'h00000001
- NUM_VECTORS, 256, vectors per run; legal 1..65535
- VALID_DELAY, 1, cycles from a vector on Data to its CheckValid; legal 0..15

Ports:
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  reset, asynchronous, active-low
- Start  in  1  run request, sampled only in IDLE
- Data  out  DATAWIDTH  current vector, registered
- DataValid  out  1  Data holds a run vector this cycle
- CheckValid  out  1  DataValid delayed VALID_DELAY cycles
- Count  out  16  vectors issued in current/last run
- Busy  out  1  high in RUN and DRAIN
- Done  out  1  one-cycle pulse at end of run

## Operation
- 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1: next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: Data=0, DataValid=0. On an edge with Start=1: Data<=SEED' (SEED with zero substitution), DataValid<=1, lfsr<=next(SEED'), Count<=1, go to RUN.
- RUN, Count<NUM_VECTORS: Data<=lfsr, lfsr<=next(lfsr), Count<=Count+1, DataValid stays 1.
- RUN, Count==NUM_VECTORS: Data<=0, DataValid<=0, drain counter<=0, go to DRAIN.
- DRAIN: stay VALID_DELAY cycles (0 means pass straight through), then go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE. Count holds NUM_VECTORS until the next Start.
- Start outside IDLE is ignored. It is not queued.
- CheckValid: VALID_DELAY-deep shift register of DataValid, cleared by reset. VALID_DELAY=0 gives CheckValid = DataValid directly (wire).
- Busy = (state==RUN) or (state==DRAIN). It is low in DONE and IDLE.

## Timing
- Reset (Rst=0, any time, asynchronous): state=IDLE, Data=0, DataValid=0, CheckValid=0, and the whole shift register=0. Also Count=0, Busy=0, Done=0, lfsr=SEED'.
- Reset mid-run aborts immediately. No Done is issued.
- Start sampled at edge k: first vector is valid in the cycle after edge k.
- Vectors are back-to-back with no bubbles. DataValid is high for exactly NUM_VECTORS cycles.
- CheckValid is high for exactly NUM_VECTORS cycles, starting VALID_DELAY cycles after DataValid rises.
- Last CheckValid cycle coincides with the last DRAIN cycle. With VALID_DELAY=0 it coincides with the last RUN cycle.
- Done is high in the cycle immediately after the last CheckValid-high cycle.
- Start held high continuously: a new run begins on the edge after DONE (one IDLE cycle between runs).
- Start=1 in the same cycle as Done is ignored, because the block is in DONE, not IDLE.
- Release of Rst is synchronized externally. The block needs no extra recovery cycles.

## Test plan
- SEED=1, NUM_VECTORS=3, VALID_DELAY=1, Start pulse: Data = 32'h00000001, 32'h80200003, 32'hC0300002 on consecutive cycles. CheckValid is high for 3 cycles, one cycle behind DataValid. Done pulses once, one cycle after the last CheckValid. Count=3.
- SEED=0: first vector 32'h00000001 (zero substitution). The LFSR never reaches 0 across 1000 steps.
- DATAWIDTH=8, SEED=32'h80200003: Data sequence 8'h03, 8'h02. Upper bits are not present.
- VALID_DELAY=0 and VALID_DELAY=15 with NUM_VECTORS=1: CheckValid is a single-cycle pulse at offset 0 and 15 from DataValid respectively. Done follows one cycle later in both cases.
- Rst asserted asynchronously (off clock edge) at vector 5 of 10: all outputs are 0 immediately with no Done. After release, Start gives a fresh run whose first vector equals SEED'.
- Start held high, NUM_VECTORS=2, VALID_DELAY=0: each run is 2 valid cycles, 1 DONE cycle, 1 IDLE cycle, repeating. Start pulses during RUN/DRAIN cause no change.

Source files
------------

// File: rtl/lfsr_stim_gen.sv
// Pseudo-random operand source for equivalence benches: a Galois LFSR drives Data,
// and a delayed copy of DataValid (CheckValid) qualifies the downstream error monitor.
module lfsr_stim_gen #(
    parameter int          DATAWIDTH   = 32,
    parameter logic [31:0] SEED        = 32'hACE12B37,
    parameter int          NUM_VECTORS = 256,
    parameter int          VALID_DELAY = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    output logic [DATAWIDTH-1:0] Data,
    output logic                 DataValid,
    output logic                 CheckValid,
    output logic [15:0]          Count,
    output logic                 Busy,
    output logic                 Done
);

    localparam logic [31:0] TAPS       = 32'h80200003;
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [31:0] SEED_FIX   = (SEED == 32'h0) ? 32'h00000001 : SEED;
    localparam logic [15:0] LAST_COUNT = 16'(NUM_VECTORS);
    localparam logic [3:0]  LAST_DRAIN = 4'(VALID_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] lfsr;
    logic [3:0]  drain_cnt;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            lfsr      <= SEED_FIX;
            Data      <= '0;
            DataValid <= 1'b0;
            Count     <= 16'd0;
            drain_cnt <= 4'd0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Data      <= '0;
                    DataValid <= 1'b0;
                    Done      <= 1'b0;
                    if (Start) begin
                        Data      <= SEED_FIX[DATAWIDTH-1:0];
                        DataValid <= 1'b1;
                        lfsr      <= lfsr_next(SEED_FIX);
                        Count     <= 16'd1;
                        Busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (Count < LAST_COUNT) begin
                        Data  <= lfsr[DATAWIDTH-1:0];
                        lfsr  <= lfsr_next(lfsr);
                        Count <= Count + 16'd1;
                    end else begin
                        Data      <= '0;
                        DataValid <= 1'b0;
                        drain_cnt <= 4'd0;
                        // With no check delay the last CheckValid is the last RUN cycle.
                        if (VALID_DELAY == 0) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (VALID_DELAY == 0) begin : g_no_delay
            assign CheckValid = DataValid;
        end else begin : g_delay
            logic [VALID_DELAY-1:0] vld_pipe;

            // Stage boundary: one register per cycle of check latency.
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe[0] <= DataValid;
                    for (int i = 1; i < VALID_DELAY; i++) begin
                        vld_pipe[i] <= vld_pipe[i-1];
                    end
                end
            end

            assign CheckValid = vld_pipe[VALID_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_lfsr_stim_gen.sv
// Scoreboard bench: six differently-configured generators share clock and reset; a model
// queues expected vectors at each accepted Start and a monitor checks every output.
module tb_lfsr_stim_gen;

    localparam int NI = 6;
    localparam int          DW_L   [NI] = '{32, 32, 8, 32, 16, 32};
    localparam logic [31:0] SEED_L [NI] = '{32'h00000001, 32'h00000000, 32'h80200003,
                                            32'hACE12B37, 32'hACE12B37, 32'h12345678};
    localparam int          NV_L   [NI] = '{3, 1000, 10, 1, 2, 1};
    localparam int          VD_L   [NI] = '{1, 2, 3, 15, 0, 0};
    localparam int          POLY_EXP [4] = '{32, 22, 2, 1};

    logic [31:0] plan_seed1 [3] = '{32'h00000001, 32'h80200003, 32'hC0300002};
    logic [31:0] plan_dw8   [2] = '{32'h00000003, 32'h00000002};

    logic        clk = 1'b1;
    logic        rst = 1'b1;
    logic        start_v [NI];
    logic [31:0] data_w  [NI];
    logic        dv [NI];
    logic        cv [NI];
    logic        bz [NI];
    logic        dn [NI];
    logic [15:0] cnt_w [NI];

    int          cyc = 0;
    bit          has [NI];
    int          run_k [NI];
    logic [31:0] exp_q [NI][$];
    bit          tb_end = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [DW_L[g]-1:0] data;

        lfsr_stim_gen #(
            .DATAWIDTH  (DW_L[g]),
            .SEED       (SEED_L[g]),
            .NUM_VECTORS(NV_L[g]),
            .VALID_DELAY(VD_L[g])
        ) u_dut (
            .Clk       (clk),
            .Rst       (rst),
            .Start     (start_v[g]),
            .Data      (data),
            .DataValid (dv[g]),
            .CheckValid(cv[g]),
            .Count     (cnt_w[g]),
            .Busy      (bz[g]),
            .Done      (dn[g])
        );

        assign data_w[g] = 32'(data);
    end

    // Feedback mask from the polynomial exponents: term x^e feeds bit e-1.
    function automatic logic [31:0] poly_taps();
        logic [31:0] t;
        t = '0;
        for (int j = 0; j < 4; j++) t = t | (32'd1 << (POLY_EXP[j] - 1));
        return t;
    endfunction

    function automatic logic [31:0] model_step(input logic [31:0] s);
        if (s % 2 == 1) return (s / 2) ^ poly_taps();
        return s / 2;
    endfunction

    function automatic logic [31:0] low_mask(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %h want %h", name, inst, $time, act, expv);
        end
    endtask

    task automatic chk_zero(input int i);
        chk("rst_Data", i, data_w[i], 32'd0);
        chk("rst_DataValid", i, 32'(dv[i]), 32'd0);
        chk("rst_CheckValid", i, 32'(cv[i]), 32'd0);
        chk("rst_Busy", i, 32'(bz[i]), 32'd0);
        chk("rst_Done", i, 32'(dn[i]), 32'd0);
        chk("rst_Count", i, 32'(cnt_w[i]), 32'd0);
    endtask

    // Reference model: decides which Start requests are accepted and queues the run's vectors.
    initial begin : model
        logic [31:0] s;
        forever begin
            @(posedge clk);
            for (int i = 0; i < NI; i++) begin
                if (!rst) begin
                    has[i] = 1'b0;
                    exp_q[i].delete();
                end else if (start_v[i] && (!has[i] || cyc > run_k[i] + NV_L[i] + VD_L[i])) begin
                    has[i]   = 1'b1;
                    run_k[i] = cyc + 1;
                    s = (SEED_L[i] == 32'd0) ? 32'd1 : SEED_L[i];
                    for (int j = 0; j < NV_L[i]; j++) begin
                        exp_q[i].push_back(s & low_mask(DW_L[i]));
                        s = model_step(s);
                    end
                end
            end
            cyc++;
        end
    end

    initial begin : monitor
        int          off;
        int          nv;
        int          vd;
        int          e_cnt;
        logic [31:0] expv;
        forever begin
            @(negedge clk or negedge rst);
            if (clk) begin
                #1;
                for (int i = 0; i < NI; i++) chk_zero(i);
            end else if (tb_end) begin
                for (int i = 0; i < NI; i++) chk("queue_drained", i, 32'(exp_q[i].size()), 32'd0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end else if (!rst) begin
                for (int i = 0; i < NI; i++) chk_zero(i);
            end else begin
                for (int i = 0; i < NI; i++) begin
                    nv    = NV_L[i];
                    vd    = VD_L[i];
                    off   = has[i] ? cyc - run_k[i] : -1;
                    e_cnt = !has[i] ? 0 : ((off + 1 < nv) ? off + 1 : nv);
                    chk("DataValid", i, 32'(dv[i]), 32'(has[i] && off < nv));
                    chk("CheckValid", i, 32'(cv[i]), 32'(has[i] && off >= vd && off < nv + vd));
                    chk("Busy", i, 32'(bz[i]), 32'(has[i] && off < nv + vd));
                    chk("Done", i, 32'(dn[i]), 32'(has[i] && off == nv + vd));
                    chk("Count", i, 32'(cnt_w[i]), 32'(e_cnt));
                    if (dv[i]) begin
                        chk("queue_has_item", i, 32'(exp_q[i].size() > 0), 32'd1);
                        if (exp_q[i].size() > 0) begin
                            expv = exp_q[i].pop_front();
                            chk("Data", i, data_w[i], expv);
                            if (i == 0 && has[i] && off >= 0 && off < 3)
                                chk("plan_seed1", i, data_w[i], plan_seed1[off]);
                            if (i == 2 && has[i] && off >= 0 && off < 2)
                                chk("plan_dw8", i, data_w[i], plan_dw8[off]);
                            if (i == 1)
                                chk("nonzero", i, 32'(data_w[i] != 32'd0), 32'd1);
                        end
                    end else begin
                        chk("Data_idle", i, data_w[i], 32'd0);
                    end
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Single Start pulse on every generator, then let all runs finish.
        @(negedge clk); #2;
        for (int i = 0; i < NI; i++) start_v[i] = 1'b1;
        @(negedge clk); #2;
        for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
        repeat (1100) @(negedge clk);

        // Abort the 10-vector run at its fifth vector with an off-edge reset.
        #2 start_v[2] = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        start_v[2] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        start_v[2] = 1'b1;
        @(negedge clk); #2;
        start_v[2] = 1'b0;
        repeat (30) @(negedge clk);

        // Random Start traffic; generator 4 keeps Start held high throughout.
        repeat (3000) begin
            @(negedge clk); #2;
            for (int i = 0; i < NI; i++)
                start_v[i] = (i == 4) ? 1'b1 : ($urandom_range(0, 3) == 0);
        end
        @(negedge clk); #2;
        for (int i = 0; i < NI; i++) start_v[i] = 1'b0;
        repeat (1100) @(negedge clk);
        #2 tb_end = 1'b1;
    end

endmodule
